// File: rtl/commit_trace_fifo.sv
// Commit trace FIFO: captures debug commit events from the core, stamps each
// with a sequence number and buffers them for the harness to drain over a
// valid/ready stream. Overflow is flagged and counted.
//
// Ports:
//   clock, reset                 rising-edge clock, async active-high reset
//   debug_commit/pc/reg_num/wdata commit event from the core
//   trace_valid, trace_ready     head-entry stream handshake
//   trace_pc/reg_num/wdata/seq   head entry fields (0 when empty)
//   trace_count                  occupancy 0..DEPTH
//   trace_overflow               sticky drop flag
//   trace_drop_cnt               saturating drop counter
//   trace_clr_ovf                clears overflow flag and drop counter
module commit_trace_fifo #(
   parameter int DEPTH     = 16,
   parameter int SEQ_W     = 32,
   parameter bit FILTER_X0 = 1'b0
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     debug_commit,
   input  logic [63:0]              debug_pc,
   input  logic [4:0]               debug_reg_num,
   input  logic [63:0]              debug_wdata,
   output logic                     trace_valid,
   input  logic                     trace_ready,
   output logic [63:0]              trace_pc,
   output logic [4:0]               trace_reg_num,
   output logic [63:0]              trace_wdata,
   output logic [SEQ_W-1:0]         trace_seq,
   output logic [$clog2(DEPTH):0]   trace_count,
   output logic                     trace_overflow,
   output logic [15:0]              trace_drop_cnt,
   input  logic                     trace_clr_ovf
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   logic [63:0]      mem_pc   [DEPTH];
   logic [4:0]       mem_reg  [DEPTH];
   logic [63:0]      mem_data [DEPTH];
   logic [SEQ_W-1:0] mem_seq  [DEPTH];

   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic [SEQ_W-1:0] seq;
   logic             overflow;
   logic [15:0]      drop_cnt;

   logic ev;
   logic full;
   logic pop;
   logic push;
   logic drop;

   assign ev   = debug_commit &&
                 !(FILTER_X0 && (debug_reg_num == 5'd0));
   assign full = (count == FULL);
   assign pop  = (count != '0) && trace_ready;
   // A full FIFO can still take an event when the head leaves this cycle.
   assign push = ev && (!full || pop);
   assign drop = ev && full && !pop;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         seq      <= '0;
         overflow <= 1'b0;
         drop_cnt <= '0;
      end else begin
         // Dropped events consume a stamp too, leaving a visible gap.
         if (ev)
            seq <= seq + 1'b1;
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)
            count <= count + 1'b1;
         else if (pop && !push)
            count <= count - 1'b1;
         // A drop in the same cycle as a clear restarts the count at 1.
         if (drop) begin
            overflow <= 1'b1;
            if (trace_clr_ovf)
               drop_cnt <= 16'd1;
            else if (drop_cnt != 16'hFFFF)
               drop_cnt <= drop_cnt + 16'd1;
         end else if (trace_clr_ovf) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (push) begin
         mem_pc[wr_ptr]   <= debug_pc;
         mem_reg[wr_ptr]  <= debug_reg_num;
         mem_data[wr_ptr] <= debug_wdata;
         mem_seq[wr_ptr]  <= seq;
      end
   end

   assign trace_valid    = (count != '0);
   assign trace_pc       = trace_valid ? mem_pc[rd_ptr]   : '0;
   assign trace_reg_num  = trace_valid ? mem_reg[rd_ptr]  : '0;
   assign trace_wdata    = trace_valid ? mem_data[rd_ptr] : '0;
   assign trace_seq      = trace_valid ? mem_seq[rd_ptr]  : '0;
   assign trace_count    = count;
   assign trace_overflow = overflow;
   assign trace_drop_cnt = drop_cnt;

endmodule

// File: tb/tb_commit_trace_fifo.sv
// Directed bench for commit_trace_fifo: one unfiltered and one
// FILTER_X0 instance share stimulus; expectations are hand-computed.
module tb_commit_trace_fifo;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        commit = 1'b0;
   logic [63:0] pc = '0;
   logic [4:0]  rnum = '0;
   logic [63:0] wdata = '0;
   logic        ready = 1'b0;
   logic        clr = 1'b0;

   logic        v0, v1;
   logic [63:0] pc0, pc1, wd0, wd1;
   logic [4:0]  rn0, rn1;
   logic [31:0] sq0, sq1;
   logic [4:0]  cnt0, cnt1;
   logic        ov0, ov1;
   logic [15:0] dc0, dc1;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   commit_trace_fifo #(.DEPTH(16), .SEQ_W(32), .FILTER_X0(1'b0)) u0 (
      .clock(clock), .reset(reset),
      .debug_commit(commit), .debug_pc(pc),
      .debug_reg_num(rnum), .debug_wdata(wdata),
      .trace_valid(v0), .trace_ready(ready),
      .trace_pc(pc0), .trace_reg_num(rn0),
      .trace_wdata(wd0), .trace_seq(sq0),
      .trace_count(cnt0), .trace_overflow(ov0),
      .trace_drop_cnt(dc0), .trace_clr_ovf(clr)
   );

   commit_trace_fifo #(.DEPTH(16), .SEQ_W(32), .FILTER_X0(1'b1)) u1 (
      .clock(clock), .reset(reset),
      .debug_commit(commit), .debug_pc(pc),
      .debug_reg_num(rnum), .debug_wdata(wdata),
      .trace_valid(v1), .trace_ready(ready),
      .trace_pc(pc1), .trace_reg_num(rn1),
      .trace_wdata(wd1), .trace_seq(sq1),
      .trace_count(cnt1), .trace_overflow(ov1),
      .trace_drop_cnt(dc1), .trace_clr_ovf(clr)
   );

   task automatic chk(input string tag,
                      input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      commit = 1'b0;
      clr    = 1'b0;
      reset  = 1'b1;
      #3;
      reset  = 1'b0;
   endtask

   logic [63:0] hold_pc;
   logic [31:0] hold_sq;
   logic        hold;
   int          rx;

   initial begin
      // 1: reset and idle
      step();
      do_reset();
      step();
      chk("rst_valid", 64'(v0), 64'd0);
      chk("rst_count", 64'(cnt0), 64'd0);
      chk("rst_pc", pc0, 64'd0);
      chk("rst_seq", 64'(sq0), 64'd0);
      chk("rst_ovf", 64'(ov0), 64'd0);
      chk("rst_drop", 64'(dc0), 64'd0);

      // 2: single commit with ready high
      commit = 1'b1;
      pc     = 64'h8000_0000;
      rnum   = 5'd5;
      wdata  = 64'h1234;
      ready  = 1'b1;
      step();
      commit = 1'b0;
      chk("t2_valid", 64'(v0), 64'd1);
      chk("t2_seq", 64'(sq0), 64'd0);
      chk("t2_pc", pc0, 64'h8000_0000);
      chk("t2_reg", 64'(rn0), 64'd5);
      chk("t2_wdata", wd0, 64'h1234);
      chk("t2_count", 64'(cnt0), 64'd1);
      step();
      chk("t2_count0", 64'(cnt0), 64'd0);
      chk("t2_valid0", 64'(v0), 64'd0);

      // 3: fill, overflow, drain
      do_reset();
      ready = 1'b0;
      rnum  = 5'd1;
      for (int i = 0; i < 16; i++) begin
         commit = 1'b1;
         pc     = 64'h1000 + 64'(i);
         step();
      end
      chk("t3_full", 64'(cnt0), 64'd16);
      chk("t3_noovf", 64'(ov0), 64'd0);
      pc = 64'hDEAD;
      step();
      commit = 1'b0;
      chk("t3_ovf", 64'(ov0), 64'd1);
      chk("t3_drop", 64'(dc0), 64'd1);
      chk("t3_cnt", 64'(cnt0), 64'd16);
      ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         chk("t3_dseq", 64'(sq0), 64'(i));
         chk("t3_dpc", pc0, 64'h1000 + 64'(i));
         step();
      end
      chk("t3_empty", 64'(cnt0), 64'd0);
      ready  = 1'b0;
      commit = 1'b1;
      pc     = 64'h2000;
      step();
      commit = 1'b0;
      chk("t3_seq17", 64'(sq0), 64'd17);
      clr = 1'b1;
      step();
      clr = 1'b0;
      chk("t3_clr_ovf", 64'(ov0), 64'd0);
      chk("t3_clr_drop", 64'(dc0), 64'd0);

      // 1b: reset mid-stream with 5 entries
      for (int i = 0; i < 4; i++) begin
         commit = 1'b1;
         step();
      end
      commit = 1'b0;
      chk("mid_cnt5", 64'(cnt0), 64'd5);
      reset = 1'b1;
      #1;
      chk("mid_cnt", 64'(cnt0), 64'd0);
      chk("mid_valid", 64'(v0), 64'd0);
      #1;
      reset  = 1'b0;
      commit = 1'b1;
      pc     = 64'h2222;
      step();
      commit = 1'b0;
      chk("mid_seq0", 64'(sq0), 64'd0);
      chk("mid_pc", pc0, 64'h2222);

      // 4: full FIFO with simultaneous push and pop
      do_reset();
      ready = 1'b0;
      for (int i = 0; i < 16; i++) begin
         commit = 1'b1;
         pc     = 64'h3000 + 64'(i);
         step();
      end
      pc    = 64'h4000;
      ready = 1'b1;
      step();
      commit = 1'b0;
      chk("t4_cnt", 64'(cnt0), 64'd16);
      chk("t4_ovf", 64'(ov0), 64'd0);
      chk("t4_head", 64'(sq0), 64'd1);
      for (int i = 0; i < 15; i++) begin
         chk("t4_dseq", 64'(sq0), 64'(i + 1));
         step();
      end
      chk("t4_tailpc", pc0, 64'h4000);
      chk("t4_tailseq", 64'(sq0), 64'd16);
      step();
      chk("t4_empty", 64'(cnt0), 64'd0);

      // 5: backpressure with ready toggling
      do_reset();
      rx   = 0;
      hold = 1'b0;
      for (int c = 0; c < 30; c++) begin
         commit = (c < 8);
         pc     = 64'h5000 + 64'(c);
         ready  = (c % 2 == 0);
         if (hold) begin
            chk("t5_hold_pc", pc0, hold_pc);
            chk("t5_hold_seq", 64'(sq0), 64'(hold_sq));
         end
         if (v0 && ready) begin
            chk("t5_rx_seq", 64'(sq0), 64'(rx));
            chk("t5_rx_pc", pc0, 64'h5000 + 64'(rx));
            rx++;
         end
         hold    = v0 && !ready;
         hold_pc = pc0;
         hold_sq = sq0;
         step();
      end
      commit = 1'b0;
      chk("t5_rx_total", 64'(rx), 64'd8);
      chk("t5_empty", 64'(cnt0), 64'd0);

      // 6: FILTER_X0 instance
      do_reset();
      ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         commit = 1'b1;
         rnum   = (i == 1) ? 5'd3 : (i == 3) ? 5'd7 : 5'd0;
         step();
      end
      commit = 1'b0;
      chk("t6_cnt", 64'(cnt1), 64'd2);
      chk("t6_nofilt_cnt", 64'(cnt0), 64'd4);
      chk("t6_seq0", 64'(sq1), 64'd0);
      chk("t6_reg0", 64'(rn1), 64'd3);
      ready = 1'b1;
      step();
      ready = 1'b0;
      chk("t6_seq1", 64'(sq1), 64'd1);
      chk("t6_reg1", 64'(rn1), 64'd7);
      rnum = 5'd1;
      for (int i = 0; i < 15; i++) begin
         commit = 1'b1;
         step();
      end
      chk("t6_full", 64'(cnt1), 64'd16);
      step();
      step();
      chk("t6_drop2", 64'(dc1), 64'd2);
      clr = 1'b1;
      step();
      chk("t6_clrdrop_ovf", 64'(ov1), 64'd1);
      chk("t6_clrdrop_cnt", 64'(dc1), 64'd1);
      commit = 1'b0;
      step();
      clr = 1'b0;
      chk("t6_clr_ovf", 64'(ov1), 64'd0);
      chk("t6_clr_cnt", 64'(dc1), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
